// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cnt_pkg
// Purpose : Shared types and constants for the prescaled step counter slice.
//           Holds the bound-handling mode enum, the direction encodings and a
//           helper that folds the reserved mode encoding onto saturate.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cnt_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2
    } cnt_mode_e;

    localparam logic CNT_DIR_UP   = 1'b0;
    localparam logic CNT_DIR_DOWN = 1'b1;

    // Encoding 3 is reserved and treated as saturate.
    function automatic cnt_mode_e decode_mode(input logic [1:0] m);
        cnt_mode_e r;
        case (m)
            2'd0:    r = CNT_WRAP;
            2'd2:    r = CNT_ONESHOT;
            default: r = CNT_SAT;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : step_prescaler
// Purpose : Programmable step qualifier. Emits a one-cycle strobe every
//           (div_i+1) enabled cycles. The count holds while en_i is low.
// Ports   : clk_i    - clock, rising edge
//           rst_ni   - asynchronous active-low reset
//           en_i     - advance enable
//           clr_i    - synchronous clear of the phase counter (wins over en_i)
//           div_i    - divisor minus one
//           strobe_o - combinational strobe, high in the qualifying cycle
// Revision: 1.0 - initial release
// ============================================================================
module step_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] div_i,
    output logic               strobe_o
);

    logic [PRESC_W-1:0] r_pc;
    logic               w_term;

    // Greater-or-equal so that lowering div_i below the current phase
    // terminates immediately instead of running round the full range.
    assign w_term   = (r_pc >= div_i);
    assign strobe_o = en_i && !clr_i && w_term;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc <= '0;
        end else if (clr_i) begin
            r_pc <= '0;
        end else if (en_i) begin
            r_pc <= w_term ? '0 : r_pc + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prescaled_step_counter.sv
`default_nettype none
// ============================================================================
// Module  : prescaled_step_counter
// Purpose : Bounded up/down step counter gated by a programmable prescaler.
//           Bound handling: wrap, saturate or one-shot. Synchronous
//           clear/load, single-cycle tick/bound pulses, sticky done level.
// Ports   : clk_i, rst_ni           - clock / async active-low reset
//           clear_i, load_i         - sync clear (priority) and load
//           load_val_i              - load value, clamped unless cfg error
//           en_i, dir_i             - count enable, direction (0 up, 1 down)
//           step_i, prescale_i      - step size, prescale divisor minus one
//           lower_i, upper_i        - inclusive bounds
//           mode_i                  - cnt_mode_e (3 acts as saturate)
//           count_o                 - registered count
//           tick_o, bound_o         - registered step / bound event pulses
//           done_o                  - one-shot finished (sticky)
//           cfg_err_o               - combinational lower_i > upper_i
// Revision: 1.0 - initial release
// ============================================================================
module prescaled_step_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   load_val_i,
    input  logic               en_i,
    input  logic               dir_i,
    input  logic [WIDTH-1:0]   step_i,
    input  logic [PRESC_W-1:0] prescale_i,
    input  logic [WIDTH-1:0]   lower_i,
    input  logic [WIDTH-1:0]   upper_i,
    input  logic [1:0]         mode_i,
    output logic [WIDTH-1:0]   count_o,
    output logic               tick_o,
    output logic               bound_o,
    output logic               done_o,
    output logic               cfg_err_o
);

    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_bound;
    logic             r_done;

    logic             w_cfg_err;
    logic             w_strobe;
    logic             w_down;
    cnt_mode_e        w_mode;

    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_lo_x;
    logic [WIDTH:0]   w_up_x;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_sum_x;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_other;
    logic             w_cross;
    logic             w_hit;
    logic             w_above;
    logic             w_below;

    logic [WIDTH-1:0] w_step_cnt;
    logic             w_step_bound;
    logic             w_step_done;
    logic [WIDTH-1:0] w_load_cnt;
    logic [WIDTH-1:0] w_clear_cnt;

    assign w_cfg_err = (lower_i > upper_i);
    assign w_down    = (dir_i == CNT_DIR_DOWN);
    assign w_mode    = decode_mode(mode_i);

    step_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en_i && !r_done && !w_cfg_err),
        .clr_i    (clear_i || load_i),
        .div_i    (prescale_i),
        .strobe_o (w_strobe)
    );

    // One extra bit of headroom keeps overflow/underflow from aliasing back
    // into the legal range before the bound comparison.
    assign w_cnt_x  = {1'b0, r_count};
    assign w_lo_x   = {1'b0, lower_i};
    assign w_up_x   = {1'b0, upper_i};
    assign w_step_x = {1'b0, step_i};
    assign w_sum_x  = w_cnt_x + w_step_x;
    assign w_diff   = r_count - step_i;

    assign w_nxt    = w_down ? w_diff  : w_sum_x[WIDTH-1:0];
    assign w_term   = w_down ? lower_i : upper_i;
    assign w_other  = w_down ? upper_i : lower_i;
    assign w_cross  = w_down ? (w_cnt_x < (w_lo_x + w_step_x))
                             : (w_sum_x > w_up_x);
    assign w_hit    = !w_cross && (w_nxt == w_term);

    assign w_above  = (r_count > upper_i);
    assign w_below  = (r_count < lower_i);

    // Result of a qualified step.
    always_comb begin
        w_step_cnt   = r_count;
        w_step_bound = 1'b0;
        w_step_done  = 1'b0;
        if (w_above || w_below) begin
            // Bounds moved under the count: snap back inside first.
            w_step_cnt   = w_above ? upper_i : lower_i;
            w_step_bound = 1'b1;
        end else if (w_mode == CNT_WRAP) begin
            // Exact landing on a bound is not a wrap; the next step wraps.
            if (w_cross) begin
                w_step_cnt   = w_other;
                w_step_bound = 1'b1;
            end else begin
                w_step_cnt   = w_nxt;
            end
        end else begin
            if (w_cross || w_hit) begin
                w_step_cnt = w_term;
                if (w_mode == CNT_ONESHOT) begin
                    w_step_bound = 1'b1;
                    w_step_done  = 1'b1;
                end else begin
                    // Saturated and already parked: hold without a new event.
                    w_step_bound = (r_count != w_term);
                end
            end else begin
                w_step_cnt = w_nxt;
            end
        end
    end

    // With inverted bounds there is no legal range to clamp into.
    always_comb begin
        w_load_cnt = load_val_i;
        if (!w_cfg_err) begin
            if (load_val_i < lower_i) begin
                w_load_cnt = lower_i;
            end else if (load_val_i > upper_i) begin
                w_load_cnt = upper_i;
            end
        end
    end

    assign w_clear_cnt = w_down ? upper_i : lower_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            r_bound <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_bound <= 1'b0;
            if (clear_i) begin
                r_count <= w_clear_cnt;
                r_done  <= 1'b0;
            end else if (load_i) begin
                r_count <= w_load_cnt;
                r_done  <= 1'b0;
            end else if (w_strobe) begin
                r_count <= w_step_cnt;
                r_tick  <= 1'b1;
                r_bound <= w_step_bound;
                if (w_step_done) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign count_o   = r_count;
    assign tick_o    = r_tick;
    assign bound_o   = r_bound;
    assign done_o    = r_done;
    assign cfg_err_o = w_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_prescaled_step_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_prescaled_step_counter
// Purpose : Directed scoreboard bench for prescaled_step_counter (W=8).
//           Expected step results are queued when stimulus is issued; a
//           monitor pops one entry on every tick_o and compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prescaled_step_counter;

    localparam int W = 8;
    localparam int P = 8;

    typedef struct {
        logic [W-1:0] cnt;
        logic         bnd;
        logic         dn;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear, load, en, dir;
    logic [W-1:0] load_val, step, lower, upper;
    logic [P-1:0] presc;
    logic [1:0]   mode;
    logic [W-1:0] count;
    logic         tick, bound, done, cfg_err;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    prescaled_step_counter #(.WIDTH(W), .PRESC_W(P)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .load_i     (load),
        .load_val_i (load_val),
        .en_i       (en),
        .dir_i      (dir),
        .step_i     (step),
        .prescale_i (presc),
        .lower_i    (lower),
        .upper_i    (upper),
        .mode_i     (mode),
        .count_o    (count),
        .tick_o     (tick),
        .bound_o    (bound),
        .done_o     (done),
        .cfg_err_o  (cfg_err)
    );

    // Monitor: every tick must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tick) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_tick: got count=%0d bound=%0d done=%0d, required no tick",
                             count, bound, done);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (count !== e.cnt || bound !== e.bnd || done !== e.dn) begin
                        bad++;
                        $display("FAIL step: got count=%0d bound=%0d done=%0d, required count=%0d bound=%0d done=%0d",
                                 count, bound, done, e.cnt, e.bnd, e.dn);
                    end
                end
            end else if (bound) begin
                total++;
                bad++;
                $display("FAIL bound_no_tick: got bound=1 tick=0, required bound=0");
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic push(input logic [W-1:0] c, input logic b, input logic d);
        exp_t e;
        e.cnt = c; e.bnd = b; e.dn = d;
        q.push_back(e);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        chk(nm, q.size(), 0);
        q.delete();
    endtask

    task automatic run_en(input int n);
        en = 1'b1;
        repeat (n) @(posedge clk);
        #1 en = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_val = v;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 0; load = 0; en = 0; dir = 0;
        load_val = '0; step = '0; lower = '0; upper = '0; presc = '0; mode = 2'd0;

        // Reset state
        #12;
        chk("rst_count", count, 0);
        chk("rst_tick",  tick,  0);
        chk("rst_done",  done,  0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: wrap up, step 3, bounds [0,10]
        lower = 0; upper = 10; step = 3; presc = 0; mode = 2'd0; dir = 1'b0;
        push(3, 0, 0); push(6, 0, 0); push(9, 0, 0); push(0, 1, 0);
        run_en(4);
        drain("t1_drain");

        // 2: saturate down, step 4, bounds [2,20], load 9
        lower = 2; upper = 20; step = 4; mode = 2'd1; dir = 1'b1;
        do_load(9);
        chk("t2_load", count, 9);
        push(5, 0, 0); push(2, 1, 0); push(2, 0, 0); push(2, 0, 0);
        run_en(4);
        drain("t2_drain");

        // 3: one-shot up, prescale 3, bounds [0,2]
        lower = 0; upper = 2; step = 1; mode = 2'd2; dir = 1'b0; presc = 3;
        do_load(0);
        push(1, 0, 0); push(2, 1, 1);
        en = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("t3_pre_step", count, 0);
        @(posedge clk); #1;
        chk("t3_step1", count, 1);
        repeat (4) @(posedge clk); #1;
        chk("t3_end_count", count, 2);
        chk("t3_done", done, 1);
        repeat (8) @(posedge clk); #1;
        en = 1'b0;
        chk("t3_frozen", count, 2);
        drain("t3_drain");
        do_load(0);
        chk("t3_reload_done", done, 0);
        push(1, 0, 0);
        run_en(4);
        drain("t3_restart_drain");
        chk("t3_restart", count, 1);

        // 4: no alias on overflow
        lower = 0; upper = 255; step = 200; mode = 2'd0; dir = 1'b0; presc = 0;
        do_load(100);
        chk("t4_load", count, 100);
        push(0, 1, 0);
        run_en(1);
        drain("t4_drain");

        // 5: clear beats load and strobe; then inverted bounds
        lower = 5; upper = 50; step = 1;
        en = 1'b1; clear = 1'b1; load = 1'b1; load_val = 30;
        @(posedge clk); #1;
        clear = 1'b0; load = 1'b0; en = 1'b0;
        chk("t5_clear", count, 5);
        chk("t5_no_tick", tick, 0);
        lower = 60; #1;
        chk("t5_cfg_err", cfg_err, 1);
        run_en(5);
        chk("t5_frozen", count, 5);
        do_load(200);
        chk("t5_load_unclamped", count, 200);
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        chk("t5_clear_err", count, 60);
        lower = 0; upper = 255; #1;
        chk("t5_cfg_ok", cfg_err, 0);
        drain("t5_drain");

        // 6: en dropped mid-prescale, then async reset
        presc = 5; step = 1;
        do_load(0);
        run_en(3);
        repeat (7) @(posedge clk); #1;
        chk("t6_hold", count, 0);
        push(1, 0, 0);
        en = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("t6_resume_early", count, 0);
        @(posedge clk); #1;
        chk("t6_resume_step", count, 1);
        en = 1'b0;
        drain("t6_drain");

        presc = 0;
        push(2, 0, 0); push(3, 0, 0);
        en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_count", count, 0);
        chk("t6_async_tick",  tick,  0);
        en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("t6_release_tick",  tick,  0);
        chk("t6_release_bound", bound, 0);
        chk("t6_release_count", count, 0);
        chk("final_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
